// File: rtl/sdram_frame_arbiter_if.sv
// rtl/sdram_frame_arbiter_if.sv - FIFO levels, SDRAM burst handshake and frame status bundle
interface sdram_frame_arbiter_if;
    logic        init_end;
    logic        pingpang_en;
    logic        read_valid;
    logic        wr_frame_rst;
    logic [9:0]  wr_fifo_num;
    logic [9:0]  rd_fifo_num;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic        sdram_wr_req;
    logic [20:0] sdram_wr_addr;
    logic        sdram_rd_req;
    logic [20:0] sdram_rd_addr;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        frame_valid;
    logic        frame_wr_done;
    logic        frame_rd_done;

    // Arbiter side
    modport master (
        input  init_end, pingpang_en, read_valid, wr_frame_rst,
        input  wr_fifo_num, rd_fifo_num, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_wr_addr, sdram_rd_req, sdram_rd_addr,
        output wr_bank, rd_bank, frame_valid, frame_wr_done, frame_rd_done
    );

    // FIFO / SDRAM controller side
    modport slave (
        output init_end, pingpang_en, read_valid, wr_frame_rst,
        output wr_fifo_num, rd_fifo_num, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_wr_addr, sdram_rd_req, sdram_rd_addr,
        input  wr_bank, rd_bank, frame_valid, frame_wr_done, frame_rd_done
    );
endinterface

// File: rtl/sdram_frame_arbiter.sv
// rtl/sdram_frame_arbiter.sv - single-port SDRAM burst scheduler with triple-buffered frame banks
module sdram_frame_arbiter #(
    parameter logic [20:0] FRAME_LEN   = 21'd307200,
    parameter logic [9:0]  BURST_LEN   = 10'd256,
    parameter logic [20:0] BANK_STRIDE = 21'd524288,
    parameter logic [9:0]  RD_URGENT   = 10'd64
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    sdram_frame_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        RD_REQ   = 3'd2,
        WR_BURST = 3'd3,
        RD_BURST = 3'd4
    } state_t;

    localparam logic [20:0] BURST_W = {11'd0, BURST_LEN};

    state_t      state_q;
    logic [20:0] wr_off_q;
    logic [20:0] rd_off_q;
    logic [1:0]  wr_bank_q;
    logic [1:0]  rd_bank_q;
    logic [1:0]  latest_q;
    logic        wr_req_q;
    logic        rd_req_q;
    logic [20:0] wr_addr_q;
    logic [20:0] rd_addr_q;
    logic        frame_valid_q;
    logic        wr_done_q;
    logic        rd_done_q;
    logic        wr_ack_q;
    logic        rd_ack_q;
    logic        wr_rst_pend_q;

    logic        wr_elig_d;
    logic        rd_elig_d;
    logic        rd_urgent_d;
    logic        wr_end_d;
    logic        rd_end_d;
    logic        wr_frame_end_d;
    logic        rd_frame_end_d;
    logic [1:0]  new_rd_bank_d;
    logic [1:0]  next_wr_bank_d;

    function automatic logic [20:0] bank_base(input logic [1:0] b);
        return 21'(b) * BANK_STRIDE;
    endfunction

    // Eligibility, burst-end detection and next write bank selection
    always_comb begin
        wr_elig_d      = bus.init_end && (bus.wr_fifo_num >= BURST_LEN);
        rd_elig_d      = bus.init_end && bus.read_valid && frame_valid_q
                         && (bus.rd_fifo_num < BURST_LEN);
        rd_urgent_d    = rd_elig_d && (bus.rd_fifo_num < RD_URGENT);
        wr_end_d       = (state_q == WR_BURST) && wr_ack_q && !bus.sdram_wr_ack;
        rd_end_d       = (state_q == RD_BURST) && rd_ack_q && !bus.sdram_rd_ack;
        wr_frame_end_d = (wr_off_q + BURST_W) >= FRAME_LEN;
        rd_frame_end_d = (rd_off_q + BURST_W) >= FRAME_LEN;
        // The very first finished frame becomes the read bank immediately.
        new_rd_bank_d  = frame_valid_q ? rd_bank_q : wr_bank_q;
        // Writer moves to the lowest bank held neither by itself nor by the reader.
        if (wr_bank_q != 2'd0 && new_rd_bank_d != 2'd0) begin
            next_wr_bank_d = 2'd0;
        end else if (wr_bank_q != 2'd1 && new_rd_bank_d != 2'd1) begin
            next_wr_bank_d = 2'd1;
        end else begin
            next_wr_bank_d = 2'd2;
        end
    end

    // Arbitration FSM, burst bookkeeping and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            wr_off_q      <= '0;
            rd_off_q      <= '0;
            wr_bank_q     <= '0;
            rd_bank_q     <= '0;
            latest_q      <= '0;
            wr_req_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            frame_valid_q <= 1'b0;
            wr_done_q     <= 1'b0;
            rd_done_q     <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            wr_rst_pend_q <= 1'b0;
        end else begin
            wr_ack_q  <= bus.sdram_wr_ack;
            rd_ack_q  <= bus.sdram_rd_ack;
            wr_addr_q <= bank_base(wr_bank_q) + wr_off_q;
            rd_addr_q <= bank_base(rd_bank_q) + rd_off_q;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            if (bus.wr_frame_rst) begin
                wr_rst_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rd_urgent_d) begin
                        state_q <= RD_REQ;
                    end else if (wr_elig_d) begin
                        state_q <= WR_REQ;
                    end else if (rd_elig_d) begin
                        state_q <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (!bus.init_end) begin
                        wr_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (wr_req_q && bus.sdram_wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= WR_BURST;
                    end else begin
                        wr_req_q <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!bus.init_end) begin
                        rd_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (rd_req_q && bus.sdram_rd_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= RD_BURST;
                    end else begin
                        rd_req_q <= 1'b1;
                    end
                end
                WR_BURST: begin
                    if (wr_end_d) begin
                        state_q <= IDLE;
                        if (wr_rst_pend_q || bus.wr_frame_rst) begin
                            wr_off_q      <= '0;
                            wr_rst_pend_q <= 1'b0;
                        end else if (!wr_frame_end_d) begin
                            wr_off_q <= wr_off_q + BURST_W;
                        end else begin
                            wr_off_q      <= '0;
                            latest_q      <= wr_bank_q;
                            wr_done_q     <= 1'b1;
                            frame_valid_q <= 1'b1;
                            if (!frame_valid_q) begin
                                rd_bank_q <= wr_bank_q;
                            end
                            wr_bank_q <= bus.pingpang_en ? next_wr_bank_d : 2'd0;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_end_d) begin
                        state_q <= IDLE;
                        if (!rd_frame_end_d) begin
                            rd_off_q <= rd_off_q + BURST_W;
                        end else begin
                            rd_off_q  <= '0;
                            rd_done_q <= 1'b1;
                            if (!bus.pingpang_en) begin
                                rd_bank_q <= 2'd0;
                            end else if (latest_q != rd_bank_q) begin
                                rd_bank_q <= latest_q;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sdram_wr_req  = wr_req_q;
    assign bus.sdram_wr_addr = wr_addr_q;
    assign bus.sdram_rd_req  = rd_req_q;
    assign bus.sdram_rd_addr = rd_addr_q;
    assign bus.wr_bank       = wr_bank_q;
    assign bus.rd_bank       = rd_bank_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_wr_done = wr_done_q;
    assign bus.frame_rd_done = rd_done_q;
endmodule
